// File: rtl/my_main_fifo.sv
// -----------------------------------------------------------------------------
// my_main_fifo
//
// Single-clock synchronous FIFO, DEPTH = 2**ADDR_W entries of DATA_W bits,
// with first-word-fall-through read data. The head-of-queue word is always
// presented on data_out, so a consumer sees the word before it reads it.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous reset, active-high; discards queued data
//   wr              in   write request (sampled at posedge clk)
//   rd              in   read request (sampled at posedge clk)
//   data_in         in   write data, sampled with wr
//   data_out        out  head-of-queue word (valid while fifo_empty = 0)
//   fifo_full       out  fill count == DEPTH
//   fifo_empty      out  fill count == 0
//   fifo_threshold  out  fill count >= THRESHOLD
//   fifo_overflow   out  sticky: write attempted while full (and no read)
//   fifo_underflow  out  sticky: read attempted while empty
//   data_count      out  fill count 0..DEPTH (only with FIFO_DATA_COUNT_EN)
//
// Build option:
//   FIFO_DATA_COUNT_EN  when defined, adds the data_count output port.
// -----------------------------------------------------------------------------
module my_main_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int THRESHOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              fifo_overflow,
`ifdef FIFO_DATA_COUNT_EN
  output logic              fifo_underflow,
  output logic [ADDR_W:0]   data_count
`else
  output logic              fifo_underflow
`endif
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] C_THRESH = (ADDR_W + 1)'(THRESHOLD);

  // Storage is never reset: stale contents are unreachable once the
  // pointers are cleared.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // One extra MSB on each pointer distinguishes full from empty when the
  // low address bits coincide.
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_overflow;
  logic            r_underflow;

  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_accept;
  logic            w_rd_accept;

  // Modulo subtraction gives the fill count directly, across wrap.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  // When full, a simultaneous read frees the head slot on the same edge, so
  // the write is accepted into it. The head word has already been consumed
  // from data_out before that edge, so overwriting it is safe.
  assign w_rd_accept = rd && !w_empty;
  assign w_wr_accept = wr && (!w_full || rd);

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Sticky error flags; cleared only by reset.
      if (wr && w_full && !rd) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Zero-latency head word: combinational read of the head location.
  assign data_out       = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign fifo_threshold = (w_count >= C_THRESH);
  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;

`ifdef FIFO_DATA_COUNT_EN
  assign data_count = w_count;
`endif

endmodule

// File: tb/tb_my_main_fifo.sv
// -----------------------------------------------------------------------------
// tb_my_main_fifo
//
// Self-checking bench for my_main_fifo. A queue-based reference model tracks
// the expected contents and sticky flags; a monitor on the falling clock edge
// compares the DUT's flags and head word against that model every cycle.
// Directed phases cover fill, overflow, drain, underflow, simultaneous
// read/write at full and empty, mid-fill reset and pointer wrap, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_my_main_fifo;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int THRESHOLD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_threshold;
  logic              fifo_overflow;
  logic              fifo_underflow;
`ifdef FIFO_DATA_COUNT_EN
  logic [ADDR_W:0]   data_count;
`endif

  my_main_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .THRESHOLD(THRESHOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr),
    .rd            (rd),
    .data_in       (data_in),
    .data_out      (data_out),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_threshold(fifo_threshold),
    .fifo_overflow (fifo_overflow),
`ifdef FIFO_DATA_COUNT_EN
    .fifo_underflow(fifo_underflow),
    .data_count    (data_count)
`else
    .fifo_underflow(fifo_underflow)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_m   = 1'b0;
  logic              udf_m   = 1'b0;
  logic              started = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;

  // Model update at each rising edge, using the inputs held stable since
  // shortly after the previous edge. Read is resolved before write so that a
  // read at full makes room for the write on the same edge, and a read at
  // empty is rejected before the write lands.
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      exp_q.delete();
      ovf_m <= 1'b0;
      udf_m <= 1'b0;
    end else begin
      if (rd && exp_q.size() == 0) udf_m <= 1'b1;
      if (wr && !rd && exp_q.size() == DEPTH) ovf_m <= 1'b1;
      if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
      if (wr && exp_q.size() < DEPTH) exp_q.push_back(data_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      check("empty",     32'(fifo_empty),     32'(exp_q.size() == 0));
      check("full",      32'(fifo_full),      32'(exp_q.size() == DEPTH));
      check("threshold", 32'(fifo_threshold), 32'(exp_q.size() >= THRESHOLD));
      check("overflow",  32'(fifo_overflow),  32'(ovf_m));
      check("underflow", 32'(fifo_underflow), 32'(udf_m));
`ifdef FIFO_DATA_COUNT_EN
      check("data_count", 32'(data_count), 32'(exp_q.size()));
`endif
      if (exp_q.size() != 0) begin
        check("data_out", 32'(data_out), 32'(exp_q[0]));
        if (rd && !rst) begin
          n_reads++;
          $display("read  data=0x%02h expected=0x%02h count=%0d", data_out, exp_q[0], exp_q.size());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    data_in = '0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Fill 0x01..0x10, one write every few cycles.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      idle(2);
    end
    // Write while full: dropped, overflow sticks.
    step(1'b1, 1'b0, 8'h11);
    idle(3);

    // Drain 16 words, then one extra read for underflow.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      idle(1);
    end
    step(1'b0, 1'b1, 8'h00);
    idle(2);

    // Simultaneous read/write while empty: count becomes 1.
    step(1'b1, 1'b1, 8'hA0);
    idle(1);
    for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    idle(1);
    // Simultaneous read/write while full: count stays 16, new tail word.
    step(1'b1, 1'b1, 8'hBB);
    idle(1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    idle(1);

    // Reset mid-fill with 5 entries, then reset clears sticky flags.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);

    // Steady 40-word stream so both pointers wrap past 2**(ADDR_W+1).
    for (int i = 0; i < 40; i++) step(1'b1, (i > 0), 8'(8'hC0 + i));
    step(1'b0, 1'b1, 8'h00);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
